// File: rtl/cdtv_sub_pkg.sv
// Shared types and default constants for the CDTV drive-side subcode serializer.
`timescale 1ns/1ps
package cdtv_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } sub_state_t;

  localparam int SUB_BITS      = 8;
  localparam int FRAME_DIV_DEF = 483;
  localparam int BLOCK_LEN_DEF = 98;
  localparam int EFFK_W_DEF    = 4;

endpackage

// File: rtl/cd_subcode_tx_scck_edge_sync.sv
// Brings the host SCCK into the CCK domain and emits a one-cycle strobe per rising edge.
`timescale 1ns/1ps
module scck_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= 3'b000;
    else       r_sync <= {r_sync[1:0], i_async};
  end

  // bits [1:0] are the metastability pair; bit 2 is only the edge-detect history
  assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/cd_subcode_tx.sv
// Drive-side subcode serializer: EFFK/SCOR frame sync plus one P..W byte shifted out per frame on SBCP.
// Optional SUBCODE_ERRCNT_EN adds saturating UNDERRUN_CNT/OVERRUN_CNT outputs.
`timescale 1ns/1ps
module cd_subcode_tx
  import cdtv_sub_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_DEF,
  parameter int EFFK_W    = EFFK_W_DEF,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
  input  logic       CCK,
  input  logic       RST,
  input  logic       SCCK,
  input  logic [7:0] SUB_DATA,
  input  logic       SUB_SYNC,
  input  logic       SUB_VALID,
  output logic       SUB_READY,
  output logic       EFFK,
  output logic       SCOR,
  output logic       SBCP,
  output logic       UNDERRUN,
  output logic       OVERRUN,
  input  logic       CLR_ERR
`ifdef SUBCODE_ERRCNT_EN
  ,
  output logic [7:0] UNDERRUN_CNT,
  output logic [7:0] OVERRUN_CNT
`endif
);

  localparam int FT_W  = $clog2(FRAME_DIV);
  localparam int BLK_W = $clog2(BLOCK_LEN);
  localparam int BIT_W = $clog2(SUB_BITS);

  logic [FT_W-1:0]  r_frame_cnt;
  logic             w_frame_start;
  logic             w_scck_rise;
  logic             r_rdy_en;
  logic             r_hold_full;
  logic [7:0]       r_hold_data;
  logic             r_hold_sync;
  sub_state_t       r_state;
  logic [3:0]       r_pulse_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [7:0]       r_shift;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_underrun;
  logic             r_overrun;
  logic             w_accept;
  logic             w_load;
  logic             w_under_ev;
  logic             w_over_ev;

  scck_edge_sync u_scck_sync (
    .i_clk   (CCK),
    .i_rst   (RST),
    .i_async (SCCK),
    .o_rise  (w_scck_rise)
  );

  // frame timer: frame_start fires as the count rolls back to 0
  assign w_frame_start = (r_frame_cnt == FT_W'(FRAME_DIV - 1));

  always_ff @(posedge CCK) begin
    if (RST)                r_frame_cnt <= '0;
    else if (w_frame_start) r_frame_cnt <= '0;
    else                    r_frame_cnt <= r_frame_cnt + FT_W'(1);
  end

  assign SUB_READY  = r_rdy_en & (~r_hold_full | w_frame_start);
  assign w_accept   = SUB_VALID & SUB_READY;
  assign w_load     = w_frame_start & (r_state != SYNC);
  assign w_under_ev = w_load & ~r_hold_full;
  assign w_over_ev  = w_frame_start & (r_state == SHIFT);

  always_ff @(posedge CCK) begin
    if (RST) begin
      r_rdy_en    <= 1'b0;
      r_hold_full <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept)           r_hold_full <= 1'b1;
      else if (w_frame_start) r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge CCK) begin
    if (w_accept) begin
      r_hold_data <= SUB_DATA;
      r_hold_sync <= SUB_SYNC;
    end
  end

  always_ff @(posedge CCK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_pulse_cnt <= '0;
      r_bit_cnt   <= '0;
      r_blk_cnt   <= '0;
    end else if (w_load) begin
      r_state     <= SYNC;
      r_pulse_cnt <= '0;
      r_bit_cnt   <= '0;
      if (r_hold_full & r_hold_sync)               r_blk_cnt <= '0;
      else if (r_blk_cnt == BLK_W'(BLOCK_LEN - 1)) r_blk_cnt <= '0;
      else                                         r_blk_cnt <= r_blk_cnt + BLK_W'(1);
    end else begin
      case (r_state)
        SYNC: begin
          if (r_pulse_cnt == 4'(EFFK_W - 1)) r_state <= SHIFT;
          else                               r_pulse_cnt <= r_pulse_cnt + 4'd1;
        end
        SHIFT: begin
          if (w_scck_rise) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (r_bit_cnt == BIT_W'(SUB_BITS - 1)) r_state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // an empty hold register sends a zero byte rather than stale data
  always_ff @(posedge CCK) begin
    if (w_load)                              r_shift <= r_hold_full ? r_hold_data : 8'h00;
    else if (r_state == SHIFT && w_scck_rise) r_shift <= {r_shift[6:0], 1'b0};
  end

  always_ff @(posedge CCK) begin
    if (RST) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_under_ev)   r_underrun <= 1'b1;
      else if (CLR_ERR) r_underrun <= 1'b0;
      if (w_over_ev)    r_overrun  <= 1'b1;
      else if (CLR_ERR) r_overrun  <= 1'b0;
    end
  end

  assign EFFK     = (r_state == SYNC);
  assign SCOR     = (r_state == SYNC) & (r_blk_cnt == '0);
  assign SBCP     = ((r_state == SYNC) | (r_state == SHIFT)) & r_shift[7];
  assign UNDERRUN = r_underrun;
  assign OVERRUN  = r_overrun;

`ifdef SUBCODE_ERRCNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] r_ucnt;
  logic [7:0] r_ocnt;

  // a clear coinciding with an event restarts the count at that event
  always_ff @(posedge CCK) begin
    if (RST) begin
      r_ucnt <= 8'h00;
      r_ocnt <= 8'h00;
    end else begin
      if (w_under_ev)   r_ucnt <= CLR_ERR ? 8'd1 : sat_inc(r_ucnt);
      else if (CLR_ERR) r_ucnt <= 8'h00;
      if (w_over_ev)    r_ocnt <= CLR_ERR ? 8'd1 : sat_inc(r_ocnt);
      else if (CLR_ERR) r_ocnt <= 8'h00;
    end
  end

  assign UNDERRUN_CNT = r_ucnt;
  assign OVERRUN_CNT  = r_ocnt;
`endif

endmodule

// File: tb/tb_cd_subcode_tx.sv
// Directed-plus-random bench for cd_subcode_tx against a frame-level reference model.
`timescale 1ns/1ps
module tb_cd_subcode_tx;

  localparam int FD = 160;
  localparam int EW = 4;
  localparam int BL = 98;

  logic       CCK       = 1'b0;
  logic       RST       = 1'b1;
  logic       SCCK      = 1'b0;
  logic [7:0] SUB_DATA  = 8'h00;
  logic       SUB_SYNC  = 1'b0;
  logic       SUB_VALID = 1'b0;
  logic       CLR_ERR   = 1'b0;
  logic       SUB_READY, EFFK, SCOR, SBCP, UNDERRUN, OVERRUN;
`ifdef SUBCODE_ERRCNT_EN
  logic [7:0] UNDERRUN_CNT, OVERRUN_CNT;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int         fidx;
  int         sync_ref;
  bit         m_full, m_hsync, m_under, m_over, m_short;
  logic [7:0] m_hold;
  logic [7:0] cur_byte;

  always #5 CCK = ~CCK;

  cd_subcode_tx #(.FRAME_DIV(FD), .EFFK_W(EW), .BLOCK_LEN(BL)) dut (
    .CCK          (CCK),
    .RST          (RST),
    .SCCK         (SCCK),
    .SUB_DATA     (SUB_DATA),
    .SUB_SYNC     (SUB_SYNC),
    .SUB_VALID    (SUB_VALID),
    .SUB_READY    (SUB_READY),
    .EFFK         (EFFK),
    .SCOR         (SCOR),
    .SBCP         (SBCP),
    .UNDERRUN     (UNDERRUN),
    .OVERRUN      (OVERRUN),
    .CLR_ERR      (CLR_ERR)
`ifdef SUBCODE_ERRCNT_EN
    ,
    .UNDERRUN_CNT (UNDERRUN_CNT),
    .OVERRUN_CNT  (OVERRUN_CNT)
`endif
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CCK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; SUB_VALID = 1'b0; SCCK = 1'b0; CLR_ERR = 1'b0;
    tick(2);
    chk1("rst_effk", EFFK, 1'b0);
    chk1("rst_scor", SCOR, 1'b0);
    chk1("rst_sbcp", SBCP, 1'b0);
    chk1("rst_ready", SUB_READY, 1'b0);
    chk1("rst_underrun", UNDERRUN, 1'b0);
    chk1("rst_overrun", OVERRUN, 1'b0);
`ifdef SUBCODE_ERRCNT_EN
    chkn("rst_ucnt", int'(UNDERRUN_CNT), 0);
    chkn("rst_ocnt", int'(OVERRUN_CNT), 0);
`endif
    RST = 1'b0;
    fidx = 0; sync_ref = -1;
    m_full = 0; m_hsync = 0; m_under = 0; m_over = 0; m_short = 0;
  endtask

  task automatic offer(input logic [7:0] d, input logic s);
    int n;
    n = 0;
    SUB_DATA = d; SUB_SYNC = s; SUB_VALID = 1'b1;
    while (SUB_READY !== 1'b1 && n < 2 * FD) begin
      tick();
      n++;
    end
    chk1("sub_ready", SUB_READY, 1'b1);
    tick();
    SUB_VALID = 1'b0;
    m_full = 1; m_hold = d; m_hsync = s;
  endtask

  task automatic next_frame(input bit chk_lat);
    int n;
    bit scor;
    n = 0;
    while (EFFK !== 1'b1 && n < 2 * FD) begin
      tick();
      n++;
    end
    chk1("effk_rise", EFFK, 1'b1);
    if (chk_lat) chkn("effk_latency", n, FD);
    if (m_short) m_over = 1;
    if (!m_full) m_under = 1;
    cur_byte = m_full ? m_hold : 8'h00;
    if (m_full && m_hsync) sync_ref = fidx;
    scor = (((fidx - sync_ref) % BL) == 0);
    chk1("underrun", UNDERRUN, m_under);
    chk1("overrun", OVERRUN, m_over);
    for (int k = 0; k < EW; k++) begin
      if (k > 0) tick();
      chk1("effk_hi", EFFK, 1'b1);
      chk1("scor", SCOR, scor);
      chk1("sbcp_sync", SBCP, cur_byte[7]);
    end
    tick();
    chk1("effk_lo", EFFK, 1'b0);
    chk1("scor_lo", SCOR, 1'b0);
    fidx++;
    m_full = 0;
    m_short = 1;
  endtask

  // host samples SBCP at each SCCK rise: byte MSB first, zeros afterwards
  task automatic pulses(input int np);
    logic [7:0] sh;
    sh = cur_byte;
    for (int i = 0; i < np; i++) begin
      chk1("sbcp_bit", SBCP, sh[7]);
      sh = {sh[6:0], 1'b0};
      SCCK = 1'b1; tick(4);
      SCCK = 1'b0; tick(4);
    end
    if (np >= 8) chk1("sbcp_done", SBCP, 1'b0);
    m_short = (np < 8);
  endtask

  task automatic clr();
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    m_under = 0; m_over = 0;
    chk1("clr_underrun", UNDERRUN, 1'b0);
    chk1("clr_overrun", OVERRUN, 1'b0);
`ifdef SUBCODE_ERRCNT_EN
    chkn("clr_ucnt", int'(UNDERRUN_CNT), 0);
    chkn("clr_ocnt", int'(OVERRUN_CNT), 0);
`endif
  endtask

  initial begin
    int unsigned r;
    do_reset();

    // basic frame with 0xA5
    offer(8'hA5, 1'b0);
    next_frame(1'b0);
    pulses(8);

    // underrun: nothing held at frame start
    next_frame(1'b0);
    pulses(8);
    clr();

    // short frame -> overrun, next byte starts at bit7
    offer(8'($urandom), 1'b0);
    next_frame(1'b0);
    pulses(5);
    offer(8'($urandom), 1'b0);
    next_frame(1'b0);
    pulses(8);
    clr();

    // surplus SCCK pulses read zero and leave the next frame intact
    offer(8'($urandom), 1'b0);
    next_frame(1'b0);
    pulses(12);
    offer(8'($urandom), 1'b0);
    next_frame(1'b0);
    pulses(8);

    // block stream: SCOR on frames 0 and 98 of the stream
    for (int b = 0; b <= BL; b++) begin
      offer(8'(b), (b == 0));
      next_frame(1'b0);
      pulses(8);
    end

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      r = $urandom;
      if ((r % 6) != 0) offer(8'($urandom), ((r % 8) == 1));
      next_frame(1'b0);
      pulses(int'($urandom_range(5, 12)));
      if ((r % 5) == 0) clr();
    end

    // reset mid-SHIFT with a byte waiting in the hold register
    offer(8'hFF, 1'b0);
    next_frame(1'b0);
    pulses(3);
    offer(8'h3C, 1'b0);
    chk1("pre_rst_sbcp", SBCP, 1'b1);
    RST = 1'b1;
    tick();
    chk1("rst_mid_effk", EFFK, 1'b0);
    chk1("rst_mid_scor", SCOR, 1'b0);
    chk1("rst_mid_sbcp", SBCP, 1'b0);
    chk1("rst_mid_ready", SUB_READY, 1'b0);
    do_reset();
    next_frame(1'b1);

`ifdef SUBCODE_ERRCNT_EN
    for (int f = 0; f < 299; f++) next_frame(1'b0);
    chkn("ucnt_sat", int'(UNDERRUN_CNT), 255);
    chkn("ocnt_sat", int'(OVERRUN_CNT), 255);
    clr();
`endif

    offer(8'h96, 1'b0);
    next_frame(1'b0);
    pulses(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
